// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- central stall/flush sequencer for the 5-stage pipeline.
//
// Combines the load-use, redirect (EX mispredict / ID jump) and memory-wait
// sources into PC enable, IF/ID hold/flush, ID/EX bubble and a whole-pipe
// freeze. A four-state FSM allows exactly one stall per load-use. It also
// tracks instruction- and data-memory waits so that a sticky timeout flag
// can flag a memory that never answers.
//
// Optional build macro HAZ_PERF_CNT_EN adds two 32-bit performance counters
// (stalled-PC cycles and IF/ID flush cycles). The control behaviour is the
// same with or without the macro.

module pipe_hazard_ctrl #(
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        br_mispredict,
  input  logic        jump_id,
  input  logic        imem_ready,
  input  logic        mem_req,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        if_id_hold,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        pipe_freeze,
  output logic        err_timeout,
  output logic [1:0]  state_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    IWAIT    = 2'd2,
    DWAIT    = 2'd3
  } state_e;

  localparam logic [TO_W-1:0] CNT_MAX = '1;

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // Hazard sources decoded from the pipeline fields.
  logic lu;
  logic redir;
  logic dstall;

  // Raw control decisions before the reset gate is applied.
  logic pc_en_c;
  logic if_id_hold_c;
  logic if_id_flush_c;
  logic id_ex_flush_c;
  logic pipe_freeze_c;

  // Load-use is only real when the load writes a non-zero register that ID reads.
  assign lu     = ex_mem_read && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign redir  = br_mispredict || jump_id;
  assign dstall = mem_req && !dmem_ready;

  // State register plus wait-timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // register samples the pre-edge values, whatever the block order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state and output decode: one priority chain shared by every state.
  // Each state only changes which sources are allowed to take part.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    pc_en_c       = 1'b0;
    if_id_hold_c  = 1'b0;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    pipe_freeze_c = 1'b0;

    if (dstall || ((state_q == DWAIT) && !dmem_ready)) begin
      // Data memory busy: freeze everything. While in DWAIT the redirect
      // sources are held upstream, so they are ignored here.
      if_id_hold_c  = 1'b1;
      pipe_freeze_c = 1'b1;
      state_d       = DWAIT;
    end else if (redir) begin
      // Redirect wins over load-use and a fetch miss: the ID instruction is
      // being discarded anyway. Only a mispredict also kills the EX-bound one.
      pc_en_c       = 1'b1;
      if_id_flush_c = 1'b1;
      id_ex_flush_c = br_mispredict;
      state_d       = RUN;
    end else if (lu && ((state_q == RUN) || (state_q == DWAIT))) begin
      // One stall cycle per load. LU_STALL and IWAIT mask lu so the same load
      // still seen in EX cannot stall a second time.
      if_id_hold_c  = 1'b1;
      id_ex_flush_c = 1'b1;
      state_d       = LU_STALL;
    end else if (!imem_ready) begin
      // Fetch not valid: hold the PC and feed a bubble into IF/ID.
      if_id_flush_c = 1'b1;
      state_d       = IWAIT;
    end else begin
      pc_en_c       = 1'b1;
      state_d       = RUN;
    end
  end

  // Wait-timeout counter: counts consecutive cycles spent in one wait state.
  always_comb begin
    cnt_d = '0;
    if (((state_q == IWAIT) || (state_q == DWAIT)) && (state_d == state_q)) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + TO_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end
    // Sticky: once set it only clears on reset. The FSM keeps waiting.
    err_d = err_q || ((TIMEOUT != 0) && (32'(cnt_d) == TIMEOUT));
  end

  // Outputs are forced low while reset is asserted, then follow the decode.
  assign pc_en       = pc_en_c       && rst_n;
  assign if_id_hold  = if_id_hold_c  && rst_n;
  assign if_id_flush = if_id_flush_c && rst_n;
  assign id_ex_flush = id_ex_flush_c && rst_n;
  assign pipe_freeze = pipe_freeze_c && rst_n;
  assign err_timeout = err_q;
  assign state_o     = state_q;

`ifdef HAZ_PERF_CNT_EN
  // Performance counters: stalled-PC cycles and IF/ID flush cycles.
  // Both wrap modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (!pc_en) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (if_id_flush) begin
        perf_flush_count <= perf_flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. A rule-level model (the cause of
// the stall for this cycle, then that cause's fixed output pattern and target
// state) is checked against the DUT at every falling edge. Directed steps also
// pin key points with hand-computed literals.

module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_mem_read, br_mispredict, jump_id;
  logic        imem_ready, mem_req, dmem_ready;
  logic        pc_en, if_id_hold, if_id_flush, id_ex_flush, pipe_freeze, err_timeout;
  logic [1:0]  state_o;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flush_count;
  int unsigned m_stall = 0, m_flush = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TO_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .br_mispredict(br_mispredict), .jump_id(jump_id),
    .imem_ready(imem_ready), .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .pipe_freeze(pipe_freeze),
    .err_timeout(err_timeout), .state_o(state_o)
`ifdef HAZ_PERF_CNT_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {C_FREEZE, C_REDIR, C_LU, C_IMISS, C_NONE} cause_e;

  int m_state  = 0;   // 0 RUN, 1 LU_STALL, 2 IWAIT, 3 DWAIT
  int m_streak = 0;   // consecutive cycles that stayed in one wait state
  bit m_err    = 0;

  // Which rule governs this cycle, given the model state and current inputs.
  function automatic cause_e cause_of(input int st);
    bit is_lu;
    is_lu = ex_mem_read && (ex_rt != 0) &&
            ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    if (!dmem_ready && (mem_req || st == 3)) return C_FREEZE;
    if (br_mispredict || jump_id)            return C_REDIR;
    if (is_lu && (st == 0 || st == 3))       return C_LU;
    if (!imem_ready)                         return C_IMISS;
    return C_NONE;
  endfunction

  // Output pattern {pc_en, if_id_hold, if_id_flush, id_ex_flush, pipe_freeze}.
  function automatic logic [4:0] outs_of(input cause_e c);
    case (c)
      C_FREEZE: return 5'b01001;
      C_REDIR:  return {1'b1, 1'b0, 1'b1, br_mispredict, 1'b0};
      C_LU:     return 5'b01010;
      C_IMISS:  return 5'b00100;
      default:  return 5'b10000;
    endcase
  endfunction

  function automatic int next_of(input cause_e c);
    case (c)
      C_FREEZE: return 3;
      C_LU:     return 1;
      C_IMISS:  return 2;
      default:  return 0;
    endcase
  endfunction

  // Advance the model on each clock edge, and reset it asynchronously.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_streak = 0; m_err = 0;
`ifdef HAZ_PERF_CNT_EN
      m_stall = 0; m_flush = 0;
`endif
    end else begin
      cause_e c;
      int     nxt;
      c   = cause_of(m_state);
      nxt = next_of(c);
`ifdef HAZ_PERF_CNT_EN
      if (!outs_of(c)[4]) m_stall++;
      if (outs_of(c)[2])  m_flush++;
`endif
      if ((m_state == 2 || m_state == 3) && nxt == m_state) m_streak++;
      else m_streak = 0;
      if (m_streak == TIMEOUT) m_err = 1;
      m_state = nxt;
    end
  end

  // Compare the DUT with the model on every falling edge.
  always @(negedge clk) begin
    logic [4:0] e;
    e = rst_n ? outs_of(cause_of(m_state)) : 5'b00000;
    check("cyc pc_en",       pc_en,       e[4]);
    check("cyc if_id_hold",  if_id_hold,  e[3]);
    check("cyc if_id_flush", if_id_flush, e[2]);
    check("cyc id_ex_flush", id_ex_flush, e[1]);
    check("cyc pipe_freeze", pipe_freeze, e[0]);
    check("cyc state_o",     state_o,     m_state);
    check("cyc err_timeout", err_timeout, m_err);
`ifdef HAZ_PERF_CNT_EN
    check("cyc perf_stall",  perf_stall_cycles, m_stall);
    check("cyc perf_flush",  perf_flush_count,  m_flush);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    ex_mem_read = 0; ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    br_mispredict = 0; jump_id = 0; imem_ready = 1; mem_req = 0; dmem_ready = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input bit emr, input int ert, input int rs, input int rt,
                       input bit urt, input bit br, input bit jmp,
                       input bit irdy, input bit mreq, input bit drdy);
    ex_mem_read = emr; ex_rt = 5'(ert); id_rs = 5'(rs); id_rt = 5'(rt);
    id_uses_rt = urt; br_mispredict = br; jump_id = jmp;
    imem_ready = irdy; mem_req = mreq; dmem_ready = drdy;
    step();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 0;
    idle();
    settle();
    check("reset pc_en", pc_en, 0);
    check("reset state", state_o, 0);
    check("reset err", err_timeout, 0);
    step(); step();
    rst_n = 1;
    settle();
    check("idle pc_en", pc_en, 1);
    step();

    // Load-use: one stall cycle, then release with the same inputs held.
    ex_mem_read = 1; ex_rt = 5; id_rs = 5;
    settle();
    check("lu c0 pc_en", pc_en, 0);
    check("lu c0 hold", if_id_hold, 1);
    check("lu c0 id_ex_flush", id_ex_flush, 1);
    step();
    check("lu c0 next state", state_o, 1);
    settle();
    check("lu c1 pc_en", pc_en, 1);
    step();
    check("lu c1 next state", state_o, 0);

    // Load to r0 never stalls.
    ex_mem_read = 1; ex_rt = 0; id_rs = 0;
    settle();
    check("r0 no stall pc_en", pc_en, 1);
    step();

    // rt match only matters when ID reads rt.
    ex_rt = 7; id_rt = 7; id_rs = 3; id_uses_rt = 0;
    settle();
    check("rt unused pc_en", pc_en, 1);
    step();
    id_uses_rt = 1;
    settle();
    check("rt used hold", if_id_hold, 1);
    step();
    idle();
    step();

    // Mispredict together with load-use: the redirect wins.
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; br_mispredict = 1;
    settle();
    check("mp+lu if_id_flush", if_id_flush, 1);
    check("mp+lu id_ex_flush", id_ex_flush, 1);
    check("mp+lu pc_en", pc_en, 1);
    check("mp+lu hold", if_id_hold, 0);
    step();
    check("mp+lu next state", state_o, 0);
    idle();

    // Data wait of three cycles; a mispredict inside DWAIT is ignored.
    mem_req = 1; dmem_ready = 0;
    settle();
    check("dw c0 freeze", pipe_freeze, 1);
    step();
    check("dw c0 state", state_o, 3);
    br_mispredict = 1;
    settle();
    check("dw c1 freeze", pipe_freeze, 1);
    check("dw c1 br ignored", if_id_flush, 0);
    step();
    check("dw c1 state", state_o, 3);
    br_mispredict = 0;
    settle();
    check("dw c2 freeze", pipe_freeze, 1);
    step();
    check("dw c2 state", state_o, 3);
    dmem_ready = 1;
    settle();
    check("dw exit freeze", pipe_freeze, 0);
    check("dw exit pc_en", pc_en, 1);
    step();
    check("dw exit state", state_o, 0);
    idle();

    // Fetch miss, then a jump resolved during IWAIT.
    imem_ready = 0;
    settle();
    check("iw c1 flush", if_id_flush, 1);
    check("iw c1 pc_en", pc_en, 0);
    step();
    check("iw c1 state", state_o, 2);
    jump_id = 1;
    settle();
    check("iw c2 pc_en", pc_en, 1);
    check("iw c2 flush", if_id_flush, 1);
    step();
    check("iw c2 state", state_o, 0);
    idle();
    step();

    // Mixed transitions, checked only by the model.
    drive(1, 5, 5, 0, 0, 0, 0, 1, 0, 1);  // lu -> LU_STALL
    drive(1, 5, 5, 0, 0, 0, 1, 1, 0, 1);  // jump in LU_STALL -> RUN
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  // fetch miss -> IWAIT
    drive(1, 5, 5, 0, 0, 0, 0, 0, 0, 1);  // lu masked in IWAIT
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);  // dstall from IWAIT -> DWAIT
    drive(1, 9, 2, 9, 1, 0, 0, 1, 1, 1);  // DWAIT exit with lu -> LU_STALL
    drive(1, 9, 2, 9, 1, 0, 0, 0, 0, 1);  // miss in LU_STALL -> IWAIT
    drive(1, 9, 2, 9, 1, 0, 0, 1, 0, 1);  // lu masked in IWAIT -> RUN
    drive(0, 0, 0, 0, 0, 1, 0, 1, 0, 1);  // plain mispredict
    idle();
    step();

    // Timeout: sets after the 4th DWAIT cycle and stays set.
    mem_req = 1; dmem_ready = 0;
    step();                               // RUN -> DWAIT
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 3) check("to after 3 err", err_timeout, 0);
    end
    check("to after 4 err", err_timeout, 1);
    dmem_ready = 1;
    step();
    check("to sticky after exit", err_timeout, 1);
    idle();
    step();

    // Asynchronous reset in the middle of a wait.
    mem_req = 1; dmem_ready = 0;
    step(); step();
    check("pre-reset state", state_o, 3);
    #2 rst_n = 0;
    #1;
    check("async rst state", state_o, 0);
    check("async rst err", err_timeout, 0);
    check("async rst freeze", pipe_freeze, 0);
    check("async rst pc_en", pc_en, 0);
    idle();
    step();
    rst_n = 1;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the PC enable, the IF/ID hold (LU_hazard) and IF/ID flush, the ID/EX bubble, and a whole-pipe freeze.
- Sources: load-use hazards, branch mispredicts from EX, jumps from ID, and instruction- and data-memory wait handshakes.
- A small FSM guarantees exactly one stall per load-use and bounded, observable memory waits.

Parameters:
- TO_W, 8: width of the wait-timeout counter.
- TIMEOUT, 200: consecutive wait cycles (IWAIT or DWAIT) after which err_timeout sets.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_mem_read  in  1  EX instruction is a load
- ex_rt  in  5  destination of the load in EX
- br_mispredict  in  1  EX branch outcome differs from prediction
- jump_id  in  1  jump/jal/jr resolved in ID
- imem_ready  in  1  fetch data valid this cycle
- mem_req  in  1  MEM stage has a load/store
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC register load enable
- if_id_hold  out  1  hold IF/ID (drives LU_hazard)
- if_id_flush  out  1  zero IF/ID
- id_ex_flush  out  1  insert bubble into ID/EX
- pipe_freeze  out  1  hold ID/EX and EX/MEM; bubble into MEM/WB
- err_timeout  out  1  sticky wait-timeout flag
- state_o  out  2  current FSM state

Behaviour:
- States: RUN=0, LU_STALL=1, IWAIT=2, DWAIT=3. Reset: state RUN, counter 0, err_timeout 0.
- Outputs are combinational from state plus inputs; the same-cycle response is required. During reset all outputs are 0 except pc_en=0.
- lu = ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- redir = br_mispredict || jump_id.
- dstall = mem_req && !dmem_ready.
- RUN evaluation, first match wins:
  - dstall: pc_en=0, if_id_hold=1, pipe_freeze=1; next DWAIT.
  - redir: pc_en=1, if_id_flush=1, id_ex_flush=br_mispredict; next RUN. A redirect overrides lu and !imem_ready in the same cycle.
  - lu: pc_en=0, if_id_hold=1, id_ex_flush=1; next LU_STALL.
  - !imem_ready: pc_en=0, if_id_flush=1; next IWAIT.
  - Otherwise: pc_en=1, all other outputs 0.
- LU_STALL: apply the RUN rules with lu forced to 0, so exactly one stall cycle occurs per load.
- IWAIT: apply the RUN rules with lu forced to 0; !imem_ready keeps the IWAIT outputs (pc_en=0, if_id_flush=1) and remains in IWAIT.
  - A redirect in IWAIT is accepted immediately and the state goes to RUN.
- DWAIT:
  - While !dmem_ready: freeze outputs as above; br_mispredict and jump_id are ignored because they are held upstream.
  - dmem_ready=1 (exit cycle): apply the RUN rules with dstall=0; next state per those rules.
- Timeout counter:
  - Clears on any cycle not in IWAIT/DWAIT and on every state change.
  - Increments each IWAIT/DWAIT cycle and saturates at 2^TO_W-1.
  - When it equals TIMEOUT, err_timeout sets. err_timeout clears only on reset.
  - The FSM keeps waiting after a timeout; it does not abort.
- Async reset mid-wait returns to RUN immediately with the counter cleared.
- Handshake: imem_ready and dmem_ready are level signals sampled every cycle. Memories hold data until a cycle in which pc_en=1 (imem) or pipe_freeze=0 (dmem).

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_stall_cycles[31:0], counting cycles with pc_en=0.
  - Adds outputs perf_flush_count[31:0], counting cycles with if_id_flush=1.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: the outputs and counters do not exist. Control behaviour is identical in both cases.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5, all ready.
  - Cycle 0: pc_en=0, if_id_hold=1, id_ex_flush=1, state_o=1.
  - Cycle 1: pc_en=1, state_o=0, even with the same inputs held.
- ex_rt=0 with id_rs=0 and ex_mem_read=1 -> no stall, pc_en=1.
- Mispredict and load-use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1, if_id_hold=0, next state RUN.
- mem_req=1, dmem_ready=0 for 3 cycles, then 1 -> pipe_freeze=1 for 3 cycles with state_o=3; exit cycle pipe_freeze=0, pc_en=1.
- imem_ready=0 for 2 cycles, jump_id=1 in the second cycle -> cycle 1: if_id_flush=1, pc_en=0; cycle 2: pc_en=1, if_id_flush=1; then RUN.
- TIMEOUT=4, dmem_ready held 0 -> err_timeout rises after the 4th DWAIT cycle and stays 1 after dmem_ready=1; rst_n low clears it and the state goes to 0.
